// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB-first, registered carry.
// Result and carry out update only on the completion edge, with a one-cycle done pulse.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic ha1_s, ha1_c;
  logic ha2_s, ha2_c;
  logic c_nxt;
  logic [WIDTH-1:0] sum_sr_nxt;

  // Two half adders plus an OR form the full-adder bit cell.
  always_comb begin
    ha1_s      = a_sr_q[0] ^ b_sr_q[0];
    ha1_c      = a_sr_q[0] & b_sr_q[0];
    ha2_s      = ha1_s ^ c_q;
    ha2_c      = ha1_s & c_q;
    c_nxt      = ha1_c | ha2_c;
    sum_sr_nxt = {ha2_s, sum_sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    cout_d   = cout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SHIFT;
          a_sr_d   = a;
          b_sr_d   = b;
          sum_sr_d = '0;
          cnt_d    = '0;
          c_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = sum_sr_nxt;
        c_d      = c_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = sum_sr_nxt;
          cout_d  = c_nxt;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: transaction-level model compared every cycle,
// plus directed adds with hand-computed results.
module tb_serial_add_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: an accepted add is outstanding for WIDTH edges, then its
  // full-precision result appears together with one done cycle.
  bit         m_act;
  int         m_rem;
  bit         m_done;
  logic [8:0] m_pend;
  logic [8:0] m_res;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_rem  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (m_act) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) begin
        m_act <= 1'b0;
        m_res <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_act  <= 1'b1;
        m_rem  <= WIDTH;
        m_pend <= {1'b0, a} + {1'b0, b};
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_act});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("sum", {24'd0, sum}, {24'd0, m_res[7:0]});
      chk("cout", {31'd0, cout}, {31'd0, m_res[8]});
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) done_cnt++;
    end
  end

  // Launch one add, optionally re-pulse start (zero operands) at cycle ign_at.
  task automatic run_add(input logic [7:0] ia, input logic [7:0] ib,
                         input int ign_at, output int cyc,
                         output int bcnt);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    cyc = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (cyc == 1) start = 1'b0;
      if (ign_at > 0 && cyc == ign_at) begin
        a = '0;
        b = '0;
        start = 1'b1;
      end
      if (ign_at > 0 && cyc == ign_at + 1) start = 1'b0;
    end while (!done && cyc < 40);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int bc;
    int dc0;
    logic [7:0] ra;
    logic [7:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Basic add
    run_add(8'h35, 8'h4A, 0, cyc, bc);
    chk("basic_latency", cyc, 32'd9);
    chk("basic_busy_cycles", bc, 32'd8);
    chk("basic_sum", {24'd0, sum}, 32'h7F);
    chk("basic_cout", {31'd0, cout}, 32'd0);

    // Carry ripple
    run_add(8'hFF, 8'h01, 0, cyc, bc);
    chk("ripple1_sum", {24'd0, sum}, 32'h00);
    chk("ripple1_cout", {31'd0, cout}, 32'd1);
    run_add(8'hFF, 8'hFF, 0, cyc, bc);
    chk("ripple2_sum", {24'd0, sum}, 32'hFE);
    chk("ripple2_cout", {31'd0, cout}, 32'd1);

    // Start while busy is ignored
    repeat (2) @(negedge clk);
    dc0 = done_cnt;
    run_add(8'h12, 8'h34, 3, cyc, bc);
    chk("ignore_latency", cyc, 32'd9);
    chk("ignore_sum", {24'd0, sum}, 32'h46);
    chk("ignore_cout", {31'd0, cout}, 32'd0);
    repeat (12) @(negedge clk);
    chk("ignore_one_done", done_cnt - dc0, 32'd1);

    // Back-to-back with start held high
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    wait_done(cyc);
    chk("b2b_sum1", {24'd0, sum}, 32'h00);
    chk("b2b_cout1", {31'd0, cout}, 32'd1);
    a = 8'h01;
    b = 8'h02;
    wait_done(cyc);
    chk("b2b_gap", cyc, 32'd9);
    chk("b2b_sum2", {24'd0, sum}, 32'h03);
    chk("b2b_cout2", {31'd0, cout}, 32'd0);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset mid-operation
    @(negedge clk);
    a = 8'hAA;
    b = 8'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    dc0 = done_cnt;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", done_cnt - dc0, 32'd0);

    // Random operands and gaps
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_add(ra, rb, 0, cyc, bc);
      chk("rand_result", {23'd0, cout, sum},
          {23'd0, {1'b0, ra} + {1'b0, rb}});
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
